fifo_wr_arbiter: RTL

- Shares the write port of the team's async FIFO between NREQ requesters in the write clock domain.
- Round-robin arbitration with packet/burst hold: a granted requester keeps the port until it sends its last word or reaches BURST words.
- Drives winc/wdata straight into the FIFO and honours wfull backpressure.
- Read side and FIFO internals are untouched.

---
 rtl/fifo_arb_pkg.sv | 31 +++
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned MAX_NREQ = 16;
  localparam int unsigned IDX_MAXW = 4;

  // Arbiter FSM encoding
  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_BURST = 1'b1;

  // Width of a counter that must hold 0..burst
  function automatic int unsigned cnt_width(input int unsigned burst);
    return $clog2(burst + 1);
  endfunction

  // Width of an index into n requesters (at least one bit)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the set bit in a one-hot vector (0 for an all-zero vector)
  function automatic logic [IDX_MAXW-1:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
    logic [IDX_MAXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) idx = idx | IDX_MAXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid request at or after ptr_i.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] winner_o,
  output logic            any_valid_o
);

  logic            found;
  logic [IDXW-1:0] idx;

  // Walk ptr_i, ptr_i+1, ... (mod NREQ) and mark the first requester seen
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDXW'((32'(ptr_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign any_valid_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO with packet/burst hold.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int unsigned CNTW = cnt_width(BURST);
  localparam int unsigned IDXW = idx_width(NREQ);

  logic [0:0]      state_q,  state_d;
  logic [NREQ-1:0] grant_q,  grant_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0] cnt_q,    cnt_d;

  logic [NREQ-1:0] winner;
  logic            any_valid;
  logic [IDXW-1:0] owner_idx;
  logic [IDXW-1:0] rr_next;
  logic            owner_valid;
  logic            owner_last;
  logic            xfer_c;
  logic            rel_c;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // Owner-side decode; grant_q is zero outside a burst so these gate themselves
  assign owner_idx   = IDXW'(onehot_to_idx(MAX_NREQ'(grant_q)));
  assign rr_next     = IDXW'((32'(owner_idx) + 32'd1) % NREQ);
  assign owner_valid = |(req_valid & grant_q);
  assign owner_last  = |(req_last & grant_q);
  assign xfer_c      = owner_valid & ~wfull;
  assign rel_c       = xfer_c & (owner_last | (cnt_q == CNTW'(BURST - 1)));

  // State, grant, pointer and burst counter registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: grant on any request, hold until last word or burst limit
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          grant_d = winner;
          cnt_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (xfer_c) cnt_d = cnt_q + CNTW'(1);
        if (rel_c) begin
          state_d  = ARB_IDLE;
          grant_d  = '0;
          rr_ptr_d = rr_next;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Write-data mux selected by the registered one-hot grant
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) wdata = wdata | req_data[i*DSIZE +: DSIZE];
    end
  end

  assign req_ready = grant_q & {NREQ{~wfull}};
  assign winc      = xfer_c;
  assign grant     = grant_q;
  assign busy      = (state_q == ARB_BURST);

endmodule
